// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Word reads/writes take one memory cycle; byte stores are read-modify-write.
module dm_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_sb,
    input  logic [31:0]   m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_sb,
    input  logic [31:0]   m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    grant,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int LW = DW / 4;

    typedef enum logic [1:0] {IDLE, XFER, MERGE, DONE} state_t;

    state_t        state;
    logic          last;
    logic          win;
    logic          mem_we_r;
    logic          lat_we;
    logic          lat_sb;
    logic [AW+1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] merge_buf;

    logic          pick;
    logic          sel_we;
    logic          sel_sb;
    logic [AW+1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          unused_addr_hi;

    function automatic logic [DW-1:0] merge_lane(input logic [DW-1:0] word,
                                                 input logic [1:0]    lane,
                                                 input logic [LW-1:0] val);
        logic [DW-1:0] r;
        r = word;
        r[int'(lane)*LW +: LW] = val;
        return r;
    endfunction

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        pick      = (m0_req && m1_req) ? ~last : m1_req;
        sel_we    = pick ? m1_we : m0_we;
        sel_sb    = pick ? (m1_sb & m1_we) : (m0_sb & m0_we);
        sel_addr  = pick ? m1_addr[AW+1:0] : m0_addr[AW+1:0];
        sel_wdata = pick ? m1_wdata : m0_wdata;
    end

    assign unused_addr_hi = ^{m0_addr[31:AW+2], m1_addr[31:AW+2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            win      <= 1'b0;
            grant    <= 2'b00;
            busy     <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            mem_we_r <= 1'b0;
        end else begin
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            mem_we_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        win      <= pick;
                        grant    <= pick ? 2'b10 : 2'b01;
                        busy     <= 1'b1;
                        mem_we_r <= sel_we & ~sel_sb;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (lat_sb) begin
                        mem_we_r <= 1'b1;
                        state    <= MERGE;
                    end else begin
                        if (!lat_we) begin
                            if (win) m1_rdata <= mem_rdata;
                            else     m0_rdata <= mem_rdata;
                        end
                        m0_ack <= ~win;
                        m1_ack <= win;
                        state  <= DONE;
                    end
                end
                MERGE: begin
                    m0_ack <= ~win;
                    m1_ack <= win;
                    state  <= DONE;
                end
                DONE: begin
                    last  <= win;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Transaction data is captured in IDLE and held for the whole access.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            lat_we    <= sel_we;
            lat_sb    <= sel_sb;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
        end
        if (state == XFER) begin
            merge_buf <= mem_rdata;
        end
    end

    // Reset masks the strobe immediately so an interrupted byte store never lands.
    assign mem_addr  = lat_addr[AW+1:2];
    assign mem_we    = mem_we_r & ~rst;
    assign mem_wdata = (state == MERGE) ? merge_lane(merge_buf, lat_addr[1:0], lat_wdata[LW-1:0])
                                        : lat_wdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural single-port memory.
module tb_dm_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0, m0_sb = 1'b0;
    logic [31:0]   m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0, m1_sb = 1'b0;
    logic [31:0]   m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic [1:0]    grant;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sb(m0_sb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sb(m1_sb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .grant(grant), .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (pre_we) mem[pre_addr] <= pre_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick;
        pre_we   = 1'b0;
    endtask

    task automatic do_sb(input logic [31:0] addr, input logic [7:0] data, input logic [DW-1:0] expw);
        int base;
        preload(10'd8, 32'h11223344);
        base = we_cnt;
        m1_req = 1'b1; m1_we = 1'b1; m1_sb = 1'b1; m1_addr = addr; m1_wdata = {24'h123456, data};
        tick;
        chk("sb_xfer_we", mem_we, 0);
        chk("sb_xfer_grant", grant, 2'b10);
        tick;
        chk("sb_merge_we", mem_we, 1);
        chk("sb_merge_addr", mem_addr, 8);
        chk("sb_merge_wdata", mem_wdata, expw);
        chk("sb_merge_ack", m1_ack, 0);
        tick;
        chk("sb_done_ack", m1_ack, 1);
        chk("sb_done_we", mem_we, 0);
        chk("sb_mem_word", mem[8], expw);
        chk("sb_we_cycles", we_cnt - base, 1);
        m1_req = 1'b0; m1_we = 1'b0; m1_sb = 1'b0;
        tick;
        chk("sb_idle_ack", m1_ack, 0);
    endtask

    logic [31:0]   sb_addr [4] = '{32'h22, 32'h20, 32'h21, 32'h23};
    logic [DW-1:0] sb_exp  [4] = '{32'h11AA3344, 32'h112233AA, 32'h1122AA44, 32'hAA223344};

    initial begin
        int base;
        // Reset state
        tick;
        tick;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_mem_we", mem_we, 0);

        // Word write then read back through m0
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        tick;
        chk("wr_busy", busy, 1);
        chk("wr_grant", grant, 2'b01);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 4);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_early_ack", m0_ack, 0);
        tick;
        chk("wr_ack", m0_ack, 1);
        chk("wr_we_off", mem_we, 0);
        chk("wr_mem_word", mem[4], 32'hDEADBEEF);
        m0_req = 1'b0; m0_we = 1'b0;
        tick;
        chk("wr_idle_busy", busy, 0);
        chk("wr_idle_grant", grant, 0);
        chk("wr_idle_ack", m0_ack, 0);
        m0_req = 1'b1; m0_addr = 32'h10;
        tick;
        chk("rd_mem_we", mem_we, 0);
        tick;
        chk("rd_ack", m0_ack, 1);
        chk("rd_data", m0_rdata, 32'hDEADBEEF);
        m0_req = 1'b0;
        tick;

        // Simultaneous requests alternate after reset
        rst = 1'b1;
        preload(10'd0, 32'hA0A0A0A0);
        preload(10'd1, 32'hB1B1B1B1);
        preload(10'd2, 32'hC2C2C2C2);
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
        tick;
        chk("rr1_grant", grant, 2'b01);
        tick;
        chk("rr1_m0_ack", m0_ack, 1);
        chk("rr1_m0_data", m0_rdata, 32'hA0A0A0A0);
        chk("rr1_m1_ack", m1_ack, 0);
        m0_addr = 32'h8;
        tick;
        chk("rr_idle_busy", busy, 0);
        tick;
        chk("rr2_grant", grant, 2'b10);
        tick;
        chk("rr2_m1_ack", m1_ack, 1);
        chk("rr2_m1_data", m1_rdata, 32'hB1B1B1B1);
        chk("rr2_m0_ack", m0_ack, 0);
        chk("rr2_m0_held", m0_rdata, 32'hA0A0A0A0);
        m1_req = 1'b0;
        tick;
        tick;
        chk("rr3_grant", grant, 2'b01);
        tick;
        chk("rr3_m0_ack", m0_ack, 1);
        chk("rr3_m0_data", m0_rdata, 32'hC2C2C2C2);
        m0_req = 1'b0;
        tick;

        // Byte stores on every lane
        for (int i = 0; i < 4; i++) begin
            do_sb(sb_addr[i], 8'hAA, sb_exp[i]);
        end

        // Reset during MERGE aborts the byte store
        preload(10'd8, 32'h11223344);
        base = we_cnt;
        m1_req = 1'b1; m1_we = 1'b1; m1_sb = 1'b1; m1_addr = 32'h22; m1_wdata = 32'hAA;
        tick;
        tick;
        rst = 1'b1;
        #1;
        chk("abort_mem_we", mem_we, 0);
        m1_req = 1'b0; m1_we = 1'b0; m1_sb = 1'b0;
        tick;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_grant", grant, 0);
        chk("abort_ack", m1_ack, 0);
        chk("abort_m1_rdata", m1_rdata, 0);
        chk("abort_m0_rdata", m0_rdata, 0);
        chk("abort_word", mem[8], 32'h11223344);
        chk("abort_we_cycles", we_cnt - base, 0);
        tick;
        chk("abort_ack_later", m1_ack, 0);
        tick;
        chk("abort_ack_later2", m1_ack, 0);

        // m0 holds req for three back-to-back reads
        m0_req = 1'b1; m0_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m0_addr = 32'(4 * i);
            chk("b2b_idle_busy", busy, 0);
            tick;
            chk("b2b_xfer_busy", busy, 1);
            chk("b2b_xfer_ack", m0_ack, 0);
            chk("b2b_xfer_m1_ack", m1_ack, 0);
            tick;
            chk("b2b_ack", m0_ack, 1);
            chk("b2b_data", m0_rdata, (i == 0) ? 32'hA0A0A0A0 : (i == 1) ? 32'hB1B1B1B1 : 32'hC2C2C2C2);
            chk("b2b_done_m1_ack", m1_ack, 0);
            tick;
        end
        m0_req = 1'b0;
        tick;

        // High address bits alias and sb is ignored on reads
        base = we_cnt;
        m1_req = 1'b1; m1_we = 1'b0; m1_sb = 1'b1; m1_addr = 32'h80001010;
        tick;
        chk("alias_addr", mem_addr, 4);
        chk("alias_we", mem_we, 0);
        tick;
        chk("alias_ack", m1_ack, 1);
        chk("alias_data", m1_rdata, 32'hDEADBEEF);
        chk("alias_no_write", we_cnt - base, 0);
        m1_req = 1'b0; m1_sb = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
